// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, queue entry and redirect FSM types shared by the fetch redirect queue
package riscv_pkg;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        pred_taken;
    } fq_entry_t;

    typedef enum logic {RUN, SQUASH} fq_state_t;

    function automatic logic [31:0] jal_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] branch_imm(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: DEPTH-entry circular buffer with flush; pointers carry an extra wrap bit
module fq_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  fq_entry_t din,
    output logic      full,
    output logic      empty,
    output fq_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fq_entry_t   mem [DEPTH];

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // pointer update; flush discards everything including same-cycle push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage write; a push into a full buffer only happens alongside a pop of the same slot
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fetch_redirect_queue.sv
// fetch_redirect_queue: buffers IF pairs for ID, predicts JAL/backward branches taken and forwards EX redirects
module fetch_redirect_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_address,
    input  logic [31:0] i_fetch_instr,
    output logic        o_fetch_hold,
    output logic        o_redirect_select,
    output logic [31:0] o_redirect_address,
    input  logic        i_ex_redirect_valid,
    input  logic [31:0] i_ex_redirect_address,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_address,
    output logic [31:0] o_id_instr,
    output logic        o_id_pred_taken
);
    localparam int CW = SQUASH_CYCLES > 0 ? $clog2(SQUASH_CYCLES + 1) : 1;

    fq_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic        full, empty, pop, accept, is_jal, is_br, taken;
    logic [31:0] target;
    fq_entry_t   head, din;

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (i_clock),
        .rst_n (i_reset_n),
        .push  (accept),
        .pop   (pop),
        .flush (i_ex_redirect_valid),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // redirect FSM state and squash counter
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // handshakes, pre-decode, redirect mux and next-state; EX redirect outranks prediction
    always_comb begin
        o_id_valid         = !empty;
        o_id_address       = empty ? '0 : head.addr;
        o_id_instr         = empty ? '0 : head.instr;
        o_id_pred_taken    = !empty && head.pred_taken;
        pop                = o_id_valid && i_id_ready;
        o_fetch_hold       = state == RUN && full && !pop;
        accept             = i_fetch_valid && !o_fetch_hold && state == RUN && !i_ex_redirect_valid;
        is_jal             = i_fetch_instr[6:0] == OPC_JAL;
        is_br              = i_fetch_instr[6:0] == OPC_BRANCH;
        target             = i_fetch_address + (is_jal ? jal_imm(i_fetch_instr) : branch_imm(i_fetch_instr));
        taken              = accept && (is_jal || (is_br && i_fetch_instr[31]));
        din                = '{addr: i_fetch_address, instr: i_fetch_instr, pred_taken: taken};
        o_redirect_select  = i_ex_redirect_valid || taken;
        o_redirect_address = i_ex_redirect_valid ? i_ex_redirect_address : taken ? target : '0;
        state_next         = state;
        cnt_next           = cnt;
        if (i_ex_redirect_valid || taken) begin
            state_next = SQUASH_CYCLES == 0 ? RUN : SQUASH;
            cnt_next   = CW'(SQUASH_CYCLES);
        end else if (state == SQUASH && i_fetch_valid) begin
            cnt_next   = cnt - CW'(1);
            state_next = cnt == CW'(1) ? RUN : SQUASH;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_queue.sv
// tb_fetch_redirect_queue: table-driven directed vectors plus reset-during-squash sequence
module tb_fetch_redirect_queue;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JAL  = 32'h0200006F;
    localparam logic [31:0] BNEG = 32'hFE000CE3;
    localparam logic [31:0] BPOS = 32'h00000463;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        fv = 0, ex = 0, rdy = 0;
    logic [31:0] fa = 0, fi = 0, ea = 0;
    logic        hold, rsel, idv, idpt;
    logic [31:0] raddr, ida, idi;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        fv;
        logic [31:0] fa, fi;
        logic        ex;
        logic [31:0] ea;
        logic        rdy;
        logic        hold, rsel;
        logic [31:0] raddr;
        logic        idv;
        logic [31:0] ida, idi;
        logic        idpt;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    fetch_redirect_queue #(.DEPTH(2), .SQUASH_CYCLES(1)) dut (
        .i_clock               (clk),
        .i_reset_n             (rst_n),
        .i_fetch_valid         (fv),
        .i_fetch_address       (fa),
        .i_fetch_instr         (fi),
        .o_fetch_hold          (hold),
        .o_redirect_select     (rsel),
        .o_redirect_address    (raddr),
        .i_ex_redirect_valid   (ex),
        .i_ex_redirect_address (ea),
        .o_id_valid            (idv),
        .i_id_ready            (rdy),
        .o_id_address          (ida),
        .o_id_instr            (idi),
        .o_id_pred_taken       (idpt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] a, input logic [31:0] i, input logic x,
                       input logic [31:0] xa, input logic r, input logic h, input logic s,
                       input logic [31:0] sa, input logic iv, input logic [31:0] ia,
                       input logic [31:0] ii, input logic ip);
        vec_t e;
        e = '{fv: v, fa: a, fi: i, ex: x, ea: xa, rdy: r, hold: h, rsel: s, raddr: sa,
              idv: iv, ida: ia, idi: ii, idpt: ip};
        vt.push_back(e);
    endtask

    initial begin
        //   fv  addr       instr ex ea        rdy hold rsel raddr     idv id_addr    id_instr pt
        add(1, 32'h00, ADDI, 0, 0,         1, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h04, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h00,    ADDI, 0);
        add(1, 32'h08, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h04,    ADDI, 0);
        add(1, 32'h0C, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h08,    ADDI, 0);
        add(1, 32'h10, JAL,  0, 0,         1, 0, 1, 32'h30,    1, 32'h0C,    ADDI, 0);
        add(1, 32'h14, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h10,    JAL,  1);
        add(1, 32'h30, ADDI, 0, 0,         1, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h40, BNEG, 0, 0,         1, 0, 1, 32'h38,    1, 32'h30,    ADDI, 0);
        add(1, 32'h44, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h40,    BNEG, 1);
        add(1, 32'h40, BPOS, 0, 0,         1, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h44, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h40,    BPOS, 0);
        add(0, 0,      0,    0, 0,         1, 0, 0, 0,         1, 32'h44,    ADDI, 0);
        add(1, 32'h48, ADDI, 0, 0,         0, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h4C, ADDI, 0, 0,         0, 0, 0, 0,         1, 32'h48,    ADDI, 0);
        add(1, 32'h50, ADDI, 0, 0,         0, 1, 0, 0,         1, 32'h48,    ADDI, 0);
        add(1, 32'h50, ADDI, 0, 0,         1, 0, 0, 0,         1, 32'h48,    ADDI, 0);
        add(0, 0,      0,    0, 0,         1, 0, 0, 0,         1, 32'h4C,    ADDI, 0);
        add(0, 0,      0,    0, 0,         1, 0, 0, 0,         1, 32'h50,    ADDI, 0);
        add(0, 0,      0,    0, 0,         1, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h60, ADDI, 0, 0,         0, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h64, ADDI, 0, 0,         0, 0, 0, 0,         1, 32'h60,    ADDI, 0);
        add(1, 32'h68, JAL,  1, 32'h100,   0, 1, 1, 32'h100,   1, 32'h60,    ADDI, 0);
        add(1, 32'h6C, ADDI, 0, 0,         0, 0, 0, 0,         0, 0,         0,    0);
        add(1, 32'h100, ADDI, 0, 0,        1, 0, 0, 0,         0, 0,         0,    0);
        add(0, 0,      0,    0, 0,         1, 0, 0, 0,         1, 32'h100,   ADDI, 0);
        add(0, 0,      0,    0, 0,         1, 0, 0, 0,         0, 0,         0,    0);

        #1;
        chk("reset id_valid", {31'b0, idv}, 0);
        chk("reset id_address", ida, 0);
        chk("reset redirect_select", {31'b0, rsel}, 0);
        chk("reset fetch_hold", {31'b0, hold}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vt.size(); k++) begin
            fv = vt[k].fv; fa = vt[k].fa; fi = vt[k].fi;
            ex = vt[k].ex; ea = vt[k].ea; rdy = vt[k].rdy;
            @(negedge clk);
            chk($sformatf("v%0d hold", k), {31'b0, hold}, {31'b0, vt[k].hold});
            chk($sformatf("v%0d redirect_select", k), {31'b0, rsel}, {31'b0, vt[k].rsel});
            chk($sformatf("v%0d redirect_address", k), raddr, vt[k].raddr);
            chk($sformatf("v%0d id_valid", k), {31'b0, idv}, {31'b0, vt[k].idv});
            if (vt[k].idv) begin
                chk($sformatf("v%0d id_address", k), ida, vt[k].ida);
                chk($sformatf("v%0d id_instr", k), idi, vt[k].idi);
                chk($sformatf("v%0d id_pred_taken", k), {31'b0, idpt}, {31'b0, vt[k].idpt});
            end
            @(posedge clk);
            #1;
        end

        // two entries queued, then reset while squashing
        fv = 1; fa = 32'h200; fi = ADDI; ex = 0; rdy = 0;
        @(negedge clk);
        chk("rs push0 hold", {31'b0, hold}, 0);
        @(posedge clk);
        #1;
        fa = 32'h204; fi = JAL;
        @(negedge clk);
        chk("rs jal redirect_select", {31'b0, rsel}, 1);
        chk("rs jal redirect_address", raddr, 32'h224);
        @(posedge clk);
        #1;
        fa = 32'h208; fi = ADDI;
        @(negedge clk);
        chk("rs squash hold forced 0", {31'b0, hold}, 0);
        chk("rs squash id_address", ida, 32'h200);
        rst_n = 0;
        #1;
        chk("rs async id_valid", {31'b0, idv}, 0);
        chk("rs async id_address", ida, 0);
        chk("rs async redirect_select", {31'b0, rsel}, 0);
        chk("rs async fetch_hold", {31'b0, hold}, 0);
        fv = 0;
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        fv = 1; fa = 32'h300; fi = ADDI; rdy = 1;
        @(negedge clk);
        chk("rs post hold", {31'b0, hold}, 0);
        chk("rs post id_valid", {31'b0, idv}, 0);
        @(posedge clk);
        #1;
        fv = 0;
        @(negedge clk);
        chk("rs post accepted id_valid", {31'b0, idv}, 1);
        chk("rs post accepted id_address", ida, 32'h300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
